// File: rtl/key_scan_pkg.sv
// rtl/key_scan_pkg.sv - shared types, timing defaults and helpers for the key scanner
//
// Purpose : per-channel FSM state encoding, default 50 MHz timing constants,
//           and the counter-width helper used by every key channel.
// Ports   : none (package)

package key_scan_pkg;

  // Per-channel debounce / hold state.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } key_fsm_e;

  // Defaults for a 50 MHz clock: 10 ms debounce, 1 s long press, 200 ms repeat.
  localparam int DEF_DB_CYCLES     = 500_000;
  localparam int DEF_LONG_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;

  // Width shared by all channel counters: enough for the largest interval,
  // plus one bit of headroom so the saturating hold counter never aliases
  // back onto the long-press match value.
  function automatic int cnt_width(input int db, input int lng, input int rep);
    int m;
    m = db;
    if (lng > m) m = lng;
    if (rep > m) m = rep;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one key: 2-FF synchroniser, debounce FSM, long-press and repeat timers
//
// Purpose : turns one raw, polarity-normalised key pin into a debounced level
//           and one-cycle press/release/long/repeat event flags.
// Ports   : clk           - system clock
//           rst_n         - asynchronous active-low reset
//           pressed_raw   - asynchronous pin, already normalised (1 = pressed)
//           key_state     - debounced level, 1 = pressed
//           press_pulse   - one cycle on accepted press
//           release_pulse - one cycle on accepted release
//           long_pulse    - one cycle when the hold time reaches LONG_CYCLES
//           repeat_pulse  - one cycle every REPEAT_CYCLES after long_pulse

module key_channel
  import key_scan_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pressed_raw,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int CW = cnt_width(DB_CYCLES, LONG_CYCLES, REPEAT_CYCLES);

  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  // Synchroniser resets to "released" so leaving reset never looks like a press.
  logic [1:0] sync;
  logic       pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], pressed_raw};
    end
  end

  assign pressed = sync[1];

  key_fsm_e      state;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] rep_cnt;
  logic          long_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      long_done     <= 1'b0;
      key_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        IDLE: begin
          if (pressed) begin
            db_cnt <= '0;
            state  <= PRESS_DB;
          end
        end

        PRESS_DB: begin
          if (!pressed) begin
            // Bounce: the stable-time count starts over.
            db_cnt <= '0;
            state  <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state       <= HELD;
            key_state   <= 1'b1;
            press_pulse <= 1'b1;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            long_done   <= 1'b0;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end

        HELD: begin
          if (hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + CW'(1);

          // Long and repeat are mutually exclusive: the long edge restarts
          // the repeat phase, so a repeat can only follow on a later cycle.
          if (!long_done && hold_cnt == LONG_LAST) begin
            long_pulse <= 1'b1;
            long_done  <= 1'b1;
            rep_cnt    <= '0;
          end else if (REPEAT_CYCLES != 0 && long_done) begin
            if (rep_cnt == REP_LAST) begin
              repeat_pulse <= 1'b1;
              rep_cnt      <= '0;
            end else begin
              rep_cnt <= rep_cnt + CW'(1);
            end
          end

          if (!pressed) begin
            db_cnt <= '0;
            state  <= REL_DB;
          end
        end

        REL_DB: begin
          // Hold and repeat timing keep running silently so that a short
          // release glitch does not shift the long/repeat schedule.
          if (hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + CW'(1);
          if (REPEAT_CYCLES != 0 && long_done) begin
            rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + CW'(1);
          end

          if (pressed) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            state         <= IDLE;
            key_state     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_scan_multi.sv
// rtl/key_scan_multi.sv - N-channel key front end: polarity normalisation and per-key channels
//
// Purpose : normalises pin polarity and instantiates one key_channel per key.
// Ports   : clk           - system clock
//           rst_n         - asynchronous active-low reset
//           key_in        - raw asynchronous key pins [N_KEYS]
//           key_state     - debounced levels, 1 = pressed [N_KEYS]
//           press_pulse   - one-cycle accepted-press flags [N_KEYS]
//           release_pulse - one-cycle accepted-release flags [N_KEYS]
//           long_pulse    - one-cycle long-press flags [N_KEYS]
//           repeat_pulse  - one-cycle auto-repeat flags [N_KEYS]

module key_scan_multi
  import key_scan_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic pressed_raw;

    assign pressed_raw = ACTIVE_LOW ? ~key_in[i] : key_in[i];

    key_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .pressed_raw  (pressed_raw),
      .key_state    (key_state[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_scan_multi.sv
// tb/tb_key_scan_multi.sv - scoreboard bench for key_scan_multi

module tb_key_scan_multi;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;

  key_scan_multi #(
    .N_KEYS       (4),
    .DB_CYCLES    (4),
    .LONG_CYCLES  (20),
    .REPEAT_CYCLES(5),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .key_state    (key_state),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] st;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] lg;
    logic [3:0] rp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push_exp(input int c, input logic [3:0] st, input logic [3:0] pr,
                          input logic [3:0] rl, input logic [3:0] lg, input logic [3:0] rp);
    exp_t e;
    e.cyc = c; e.st = st; e.pr = pr; e.rl = rl; e.lg = lg; e.rp = rp;
    q.push_back(e);
  endtask

  // Wait for the falling edge after rising edge number c; inputs set here are
  // first sampled by rising edge c+1.
  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: any pulse, or an expected event falling due, consumes one entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((|{press_pulse, release_pulse, long_pulse, repeat_pulse}) ||
          (q.size() > 0 && q[0].cyc == cyc)) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event cyc=%0d st=%b pr=%b rl=%b lg=%b rp=%b (want no event)",
                   cyc, key_state, press_pulse, release_pulse, long_pulse, repeat_pulse);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.cyc != cyc || e.st != key_state || e.pr != press_pulse ||
              e.rl != release_pulse || e.lg != long_pulse || e.rp != repeat_pulse) begin
            n_bad++;
            $display("FAIL event got cyc=%0d st=%b pr=%b rl=%b lg=%b rp=%b want cyc=%0d st=%b pr=%b rl=%b lg=%b rp=%b",
                     cyc, key_state, press_pulse, release_pulse, long_pulse, repeat_pulse,
                     e.cyc, e.st, e.pr, e.rl, e.lg, e.rp);
          end
        end
      end
    end
  end

  task automatic check_outs_zero(input string name);
    n_cmp++;
    if ({key_state, press_pulse, release_pulse, long_pulse, repeat_pulse} != 20'h0) begin
      n_bad++;
      $display("FAIL %s got st=%b pr=%b rl=%b lg=%b rp=%b want all 0", name,
               key_state, press_pulse, release_pulse, long_pulse, repeat_pulse);
    end
  endtask

  initial begin
    key_in = 4'hF;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    check_outs_zero("reset_state");
    rst_n = 1'b1;

    // Clean press / release on channel 0.
    push_exp(16, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push_exp(27, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    at(9);  key_in[0] = 1'b0;
    at(20); key_in[0] = 1'b1;

    // Bounce on channel 1, then steady press and release.
    push_exp(57, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    push_exp(67, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      at(30 + 2 * k);
      key_in[1] = k[0];
    end
    at(50); key_in[1] = 1'b0;
    at(60); key_in[1] = 1'b1;

    // Long press with auto-repeat on channel 2.
    push_exp(77, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    push_exp(97, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    for (int r = 0; r < 7; r++)
      push_exp(102 + 5 * r, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push_exp(140, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    at(70);  key_in[2] = 1'b0;
    at(133); key_in[2] = 1'b1;

    // Two-cycle release glitch on channel 3 while held.
    push_exp(157, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    push_exp(177, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    push_exp(182, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    push_exp(187, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    at(150); key_in[3] = 1'b0;
    at(160); key_in[3] = 1'b1;
    at(162); key_in[3] = 1'b0;
    at(180); key_in[3] = 1'b1;

    // Release channels 0 and 3 while pressing channel 1 in the same cycle.
    push_exp(197, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    push_exp(207, 4'b0010, 4'b0010, 4'b1001, 4'b0000, 4'b0000);
    at(190); key_in = 4'b0110;
    at(200); key_in = 4'b1101;

    // Reset mid-hold on channel 1.
    at(215);
    n_cmp++;
    if (key_state != 4'b0010) begin
      n_bad++;
      $display("FAIL pre_reset_state got %b want 0010", key_state);
    end
    #2 rst_n = 1'b0;
    #1 check_outs_zero("async_reset");
    key_in = 4'hF;
    at(220); rst_n = 1'b1;
    at(320);
    check_outs_zero("post_reset_idle");

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events got %0d left want 0 (next due cyc=%0d)", q.size(), q[0].cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
